// File: rtl/add_sub_pipe_64bit_pkg.sv
// Shared constants for the 64-bit add/subtract pipeline: datapath width and flag-vector bit positions.
package add_sub_pipe_64bit_pkg;
    localparam int ASP_WIDTH = 64;
    localparam int NFLAGS    = 4;
    localparam int FLAG_C    = 3;
    localparam int FLAG_V    = 2;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 0;
    localparam int CLA_GRP   = 4;

    typedef logic [NFLAGS-1:0] flags_t;
endpackage

// File: rtl/add_sub_pipe_64bit_cla.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module carry_lookahead_adder_64bit
    import add_sub_pipe_64bit_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);
    localparam int NGRP = 64 / CLA_GRP;

    logic [63:0] g, p, c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        logic [3:0] gg, pp;
        logic       ci, co;
        assign gg = g[4*k +: 4];
        assign pp = p[4*k +: 4];
        // Group carry-in comes from the previous group's lookahead output.
        if (k == 0) begin : g_first
            assign ci = cin_i;
        end else begin : g_rest
            assign ci = g_grp[k-1].co;
        end
        assign c[4*k]   = ci;
        assign c[4*k+1] = gg[0] | (pp[0] & ci);
        assign c[4*k+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
        assign c[4*k+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                        | (pp[2] & pp[1] & pp[0] & ci);
        assign co       = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                        | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & ci);
    end

    assign sum_o  = p ^ c;
    assign cout_o = g_grp[NGRP-1].co;
endmodule

// File: rtl/add_sub_pipe_64bit.sv
// Two-stage valid/ready add/subtract pipeline (S1 operands, S2 result + flags).
// Define ADD_SUB_PIPE_FLAGS_EN to compute and register C/V/Z/N; otherwise flags read 0.
module add_sub_pipe_64bit
    import add_sub_pipe_64bit_pkg::*;
#(
    parameter int WIDTH = ASP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_z,
    output logic             flag_n
);
    if (WIDTH != ASP_WIDTH) begin : g_width_chk
        $error("add_sub_pipe_64bit: WIDTH must be 64");
    end

    logic             v1_q, v1_d, v2_q, v2_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, sum;
    logic             cin_q;
    logic             s1_adv, in_xfer, s2_load;
`ifdef ADD_SUB_PIPE_FLAGS_EN
    logic             cout;
`else
    logic             cout_unused;
`endif

    assign s1_adv   = !v2_q || out_ready;
    assign in_ready = flush || !v1_q || s1_adv;
    assign in_xfer  = in_valid && in_ready && !flush;
    assign s2_load  = v1_q && s1_adv && !flush;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        if (flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
        end else begin
            if (s1_adv) begin
                v2_d = v1_q;
                v1_d = 1'b0;
            end
            if (in_xfer) v1_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // Operand B is pre-inverted so the adder always computes A + B' + cin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else if (in_xfer) begin
            a_q   <= op_a;
            b_q   <= op_b ^ {WIDTH{op_sub}};
            cin_q <= op_sub;
        end
    end

    carry_lookahead_adder_64bit u_cla (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (cin_q),
        .sum_o  (sum),
`ifdef ADD_SUB_PIPE_FLAGS_EN
        .cout_o (cout)
`else
        .cout_o (cout_unused)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       res_q <= '0;
        else if (s2_load) res_q <= sum;
    end

`ifdef ADD_SUB_PIPE_FLAGS_EN
    flags_t flags_q, flags_d;

    always_comb begin
        flags_d         = '0;
        flags_d[FLAG_C] = cout;
        flags_d[FLAG_V] = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        flags_d[FLAG_Z] = (sum == '0);
        flags_d[FLAG_N] = sum[WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       flags_q <= '0;
        else if (s2_load) flags_q <= flags_d;
    end

    assign flag_c = flags_q[FLAG_C];
    assign flag_v = flags_q[FLAG_V];
    assign flag_z = flags_q[FLAG_Z];
    assign flag_n = flags_q[FLAG_N];
`else
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
    assign flag_z = 1'b0;
    assign flag_n = 1'b0;
`endif

    assign out_valid = v2_q;
    assign result    = res_q;
endmodule

// File: tb/tb_add_sub_pipe_64bit.sv
// Self-checking bench for add_sub_pipe_64bit: directed corner cases plus randomized streaming
// against an arithmetic reference model held in a queue.
module tb_add_sub_pipe_64bit;
`ifdef ADD_SUB_PIPE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        in_ready, out_valid;
    logic [63:0] result;
    logic        flag_c, flag_v, flag_z, flag_n;
    logic [3:0]  flg;

    assign flg = {flag_c, flag_v, flag_z, flag_n};

    always #5 clk = ~clk;

    add_sub_pipe_64bit #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    int          checks = 0;
    int          errors = 0;
    int          n_out = 0;
    bit          last_acc;
    logic [67:0] sb[$];

    // Reference: {result, C, V, Z, N} from plain arithmetic on the operands.
    function automatic logic [67:0] ref_op(input logic [63:0] a, input logic [63:0] b, input bit s);
        logic [64:0] f;
        logic [63:0] r;
        logic        c, v;
        if (s) begin
            r = a - b;
            c = (a >= b);
            v = (a[63] != b[63]) && (r[63] != a[63]);
        end else begin
            f = {1'b0, a} + {1'b0, b};
            r = f[63:0];
            c = f[64];
            v = (a[63] == b[63]) && (r[63] != a[63]);
        end
        return {r, FLAGS ? {c, v, (r == 64'd0), r[63]} : 4'b0000};
    endfunction

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at the negedge, settle, score the handshake, then advance past the posedge.
    task automatic drive(input bit iv, input logic [63:0] a, input logic [63:0] b,
                         input bit s, input bit ordy, input bit fl);
        logic [67:0] e;
        in_valid = iv; op_a = a; op_b = b; op_sub = s; out_ready = ordy; flush = fl;
        #1;
        last_acc = iv && in_ready && !fl;
        if (out_valid && out_ready && !fl) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 68'(result), 68'(0));
            end else begin
                e = sb.pop_front();
                chk("stream", {result, flg}, e);
                n_out++;
            end
        end
        if (fl) sb.delete();
        if (last_acc) sb.push_back(ref_op(a, b, s));
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        int          idx, sent, n0;
        logic [63:0] hold, ra, rb;

        // Reset state
        #1;
        chk("rst_out_valid", 68'(out_valid), 68'(0));
        chk("rst_in_ready",  68'(in_ready),  68'(1));
        chk("rst_result",    68'(result),    68'(0));
        chk("rst_flags",     68'(flg),       68'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Add wrap-around; output appears after the second register edge
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 0);
        chk("lat_s1_only", 68'(out_valid), 68'(0));
        drive(0, '0, '0, 0, 1, 0);
        chk("add_valid",  68'(out_valid), 68'(1));
        chk("add_result", 68'(result),    68'(0));
        chk("add_flags",  68'(flg),       68'(FLAGS ? 4'b1010 : 4'b0000));
        drive(0, '0, '0, 0, 1, 0);

        // Subtract with signed overflow
        drive(1, 64'h8000_0000_0000_0000, 64'd1, 1, 1, 0);
        drive(0, '0, '0, 0, 1, 0);
        chk("sub_result", 68'(result), 68'(64'h7FFF_FFFF_FFFF_FFFF));
        chk("sub_flags",  68'(flg),    68'(FLAGS ? 4'b1100 : 4'b0000));
        drive(0, '0, '0, 0, 1, 0);
        chk("sub_drained", 68'(sb.size()), 68'(0));

        // Back-pressure: out_ready low for 5 cycles
        idx = 0;
        hold = '0;
        for (int c = 0; c < 5; c++) begin
            drive(idx < 3, 64'(idx + 1), 64'd10, 0, 0, 0);
            if (last_acc) idx++;
            if (c == 2) hold = result;
            if (c > 2) chk("bp_result_stable", 68'(result), 68'(hold));
        end
        chk("bp_accepted",  68'(idx),       68'(2));
        chk("bp_in_ready",  68'(in_ready),  68'(0));
        chk("bp_out_valid", 68'(out_valid), 68'(1));
        chk("bp_head",      68'(result),    68'(11));
        n0 = n_out;
        for (int c = 0; c < 20 && !(idx == 3 && sb.size() == 0); c++) begin
            drive(idx < 3, 64'(idx + 1), 64'd10, 0, 1, 0);
            if (last_acc) idx++;
        end
        chk("bp_count", 68'(n_out - n0), 68'(3));

        // Randomized streaming with random valid / ready
        sent = 0;
        n0 = n_out;
        for (int c = 0; c < 3000 && (sent < 100 || sb.size() != 0); c++) begin
            ra = {$urandom, $urandom};
            rb = ($urandom_range(7) == 0) ? ra : {$urandom, $urandom};
            drive((sent < 100) && 1'($urandom_range(1)), ra, rb, 1'($urandom_range(1)),
                  1'($urandom_range(1)), 0);
            if (last_acc) sent++;
        end
        chk("stream_sent",  68'(sent),        68'(100));
        chk("stream_count", 68'(n_out - n0),  68'(100));

        // Flush with both stages full
        idx = 0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            drive(1, 64'(100 + c), 64'd1, 0, 0, 0);
            if (last_acc) idx++;
        end
        chk("fl_full", 68'(out_valid), 68'(1));
        in_valid = 1'b1; op_a = 64'hDEAD; op_b = 64'd1; op_sub = 1'b0;
        out_ready = 1'b0; flush = 1'b1;
        #1;
        chk("fl_in_ready", 68'(in_ready), 68'(1));
        sb.delete();
        @(negedge clk);
        flush = 1'b0;
        chk("fl_out_valid", 68'(out_valid), 68'(0));
        n0 = n_out;
        for (int c = 0; c < 4; c++) drive(0, '0, '0, 0, 1, 0);
        chk("fl_no_emerge", 68'(n_out - n0), 68'(0));
        chk("fl_idle",      68'(out_valid),  68'(0));

        // Asynchronous reset with two beats in flight
        idx = 0;
        for (int c = 0; c < 10 && idx < 2; c++) begin
            drive(1, 64'(200 + c), 64'd7, 0, 0, 0);
            if (last_acc) idx++;
        end
        chk("ar_full", 68'(out_valid), 68'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 68'(out_valid), 68'(0));
        chk("ar_in_ready",  68'(in_ready),  68'(1));
        chk("ar_result",    68'(result),    68'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 64'd5, 64'd3, 1, 1, 0);
        drive(0, '0, '0, 0, 1, 0);
        chk("ar_new_result", 68'(result), 68'(2));
        chk("ar_new_flags",  68'(flg),    68'(FLAGS ? 4'b1000 : 4'b0000));
        drive(0, '0, '0, 0, 1, 0);
        chk("ar_drained", 68'(sb.size()), 68'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
